// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment display driver.
// Segment codes are active-low, packed as {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } digit_idx_t;

   localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
   localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
   localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
   localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
   localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
   localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
   localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
   localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
   localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
   localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
   localparam logic [6:0] SEG_HEX_A = 7'b0001000;
   localparam logic [6:0] SEG_HEX_B = 7'b0000011;
   localparam logic [6:0] SEG_HEX_C = 7'b1000110;
   localparam logic [6:0] SEG_HEX_D = 7'b0100001;
   localparam logic [6:0] SEG_HEX_E = 7'b0000110;
   localparam logic [6:0] SEG_HEX_F = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder ({g,f,e,d,c,b,a}).
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      case (nib)
         4'h0: seg_n = SEG_HEX_0;
         4'h1: seg_n = SEG_HEX_1;
         4'h2: seg_n = SEG_HEX_2;
         4'h3: seg_n = SEG_HEX_3;
         4'h4: seg_n = SEG_HEX_4;
         4'h5: seg_n = SEG_HEX_5;
         4'h6: seg_n = SEG_HEX_6;
         4'h7: seg_n = SEG_HEX_7;
         4'h8: seg_n = SEG_HEX_8;
         4'h9: seg_n = SEG_HEX_9;
         4'hA: seg_n = SEG_HEX_A;
         4'hB: seg_n = SEG_HEX_B;
         4'hC: seg_n = SEG_HEX_C;
         4'hD: seg_n = SEG_HEX_D;
         4'hE: seg_n = SEG_HEX_E;
         4'hF: seg_n = SEG_HEX_F;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode hex display with frame-synchronous double-buffered updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 500
) (
   input  logic        fpga_clk1,
   input  logic        reset,
   input  logic [15:0] value_in,
   input  logic        value_valid,
   input  logic [3:0]  dp_in,
   output logic        seg0,
   output logic        seg1,
   output logic        seg2,
   output logic        seg3,
   output logic        seg4,
   output logic        seg5,
   output logic        seg6,
   output logic        dp,
   output logic        an0,
   output logic        an1,
   output logic        an2,
   output logic        an3,
   output logic        frame_done
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   digit_idx_t       dig_q, dig_d;
   logic             pend_q, pend_d;
   logic [19:0]      pend_val_q, pend_val_d;
   logic [19:0]      disp_q, disp_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             frame_done_q, frame_done_d;

   logic             slot_end;
   logic             frame_end;
   logic [3:0]       cur_nib;
   logic             cur_dp;
   logic             cur_blank;
   logic [6:0]       dec_seg;

   // Slot/digit sequencing: each digit owns REFRESH_DIV cycles, DIG0..DIG3 then repeat.
   always_comb begin
      slot_end  = (cnt_q == CNT_MAX);
      frame_end = slot_end && (dig_q == DIG3);
      cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
      dig_d     = dig_q;
      if (slot_end) begin
         case (dig_q)
            DIG0:    dig_d = DIG1;
            DIG1:    dig_d = DIG2;
            DIG2:    dig_d = DIG3;
            DIG3:    dig_d = DIG0;
            default: dig_d = DIG0;
         endcase
      end
   end

   // A strobe landing on the frame boundary bypasses the pending buffer entirely.
   always_comb begin
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      disp_d     = disp_q;
      if (frame_end) begin
         if (value_valid) begin
            disp_d = {dp_in, value_in};
         end else if (pend_q) begin
            disp_d = pend_val_q;
         end
         pend_d = 1'b0;
      end else if (value_valid) begin
         pend_val_d = {dp_in, value_in};
         pend_d     = 1'b1;
      end
   end

   always_comb begin
      cur_nib = disp_q[3:0];
      cur_dp  = disp_q[16];
      case (dig_q)
         DIG0:    begin cur_nib = disp_q[3:0];   cur_dp = disp_q[16]; end
         DIG1:    begin cur_nib = disp_q[7:4];   cur_dp = disp_q[17]; end
         DIG2:    begin cur_nib = disp_q[11:8];  cur_dp = disp_q[18]; end
         DIG3:    begin cur_nib = disp_q[15:12]; cur_dp = disp_q[19]; end
         default: begin cur_nib = disp_q[3:0];   cur_dp = disp_q[16]; end
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is blank only if it and every higher digit are zero with no lit point.
   logic [3:1] lz;
   always_comb begin
      lz[3] = (disp_q[15:12] == 4'h0) && !disp_q[19];
      lz[2] = lz[3] && (disp_q[11:8] == 4'h0) && !disp_q[18];
      lz[1] = lz[2] && (disp_q[7:4] == 4'h0) && !disp_q[17];
      cur_blank = 1'b0;
      case (dig_q)
         DIG1:    cur_blank = lz[1];
         DIG2:    cur_blank = lz[2];
         DIG3:    cur_blank = lz[3];
         default: cur_blank = 1'b0;
      endcase
   end
`else
   assign cur_blank = 1'b0;
`endif

   hex_to_seg7 u_dec (
      .nib   (cur_nib),
      .seg_n (dec_seg)
   );

   // Output register stage: anodes gated during the blanking window, segments are not.
   always_comb begin
      an_d = 4'b1111;
      if (cnt_q >= BLANK_END) begin
         case (dig_q)
            DIG0:    an_d = 4'b1110;
            DIG1:    an_d = 4'b1101;
            DIG2:    an_d = 4'b1011;
            DIG3:    an_d = 4'b0111;
            default: an_d = 4'b1111;
         endcase
      end
      seg_d        = cur_blank ? SEG_BLANK : dec_seg;
      dp_d         = ~cur_dp;
      frame_done_d = frame_end;
   end

   always_ff @(posedge fpga_clk1) begin
      if (reset) begin
         cnt_q        <= '0;
         dig_q        <= DIG0;
         pend_q       <= 1'b0;
         pend_val_q   <= '0;
         disp_q       <= '0;
         an_q         <= 4'b1111;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         dig_q        <= dig_d;
         pend_q       <= pend_d;
         pend_val_q   <= pend_val_d;
         disp_q       <= disp_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign {seg6, seg5, seg4, seg3, seg2, seg1, seg0} = seg_q;
   assign dp         = dp_q;
   assign {an3, an2, an1, an0} = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (REFRESH_DIV=4, BLANK_CYC=1).
// Optional LEADING_ZERO_BLANK_EN build is covered when the macro is defined.
module tb_seg7_scan_driver;

   localparam int DIV   = 4;
   localparam int BLANK = 1;
   localparam int FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value_in;
   logic        value_valid;
   logic [3:0]  dp_in;
   logic        seg0, seg1, seg2, seg3, seg4, seg5, seg6, dp;
   logic        an0, an1, an2, an3, frame_done;
   logic [6:0]  seg_w;
   logic [3:0]  an_w;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
      .fpga_clk1   (clk),
      .reset       (reset),
      .value_in    (value_in),
      .value_valid (value_valid),
      .dp_in       (dp_in),
      .seg0        (seg0),
      .seg1        (seg1),
      .seg2        (seg2),
      .seg3        (seg3),
      .seg4        (seg4),
      .seg5        (seg5),
      .seg6        (seg6),
      .dp          (dp),
      .an0         (an0),
      .an1         (an1),
      .an2         (an2),
      .an3         (an3),
      .frame_done  (frame_done)
   );

   assign seg_w = {seg6, seg5, seg4, seg3, seg2, seg1, seg0};
   assign an_w  = {an3, an2, an1, an0};

   // Standard hex glyphs, {g..a}, active-low.
   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Model: p = cycles since reset release; the shown value changes only at frame ends.
   int          p;
   logic [19:0] m_disp, m_pend_val;
   bit          m_pend;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp, exp_fd;

   function automatic logic [3:0] model_an(int pos);
      int d;
      d = (pos / DIV) % 4;
      if ((pos % DIV) < BLANK) return 4'hF;
      return ~(4'b0001 << d);
   endfunction

   function automatic logic [6:0] model_seg(int pos, logic [19:0] v);
      int d;
      bit blank;
      d = (pos / DIV) % 4;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0) begin
         blank = 1'b1;
         for (int k = d; k < 4; k++)
            if (v[4*k +: 4] != 4'h0 || v[16+k]) blank = 1'b0;
      end
`endif
      return blank ? 7'h7F : seg_tbl[v[4*d +: 4]];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         p          <= 0;
         m_disp     <= '0;
         m_pend_val <= '0;
         m_pend     <= 1'b0;
         exp_an     <= 4'hF;
         exp_seg    <= 7'h7F;
         exp_dp     <= 1'b1;
         exp_fd     <= 1'b0;
      end else begin
         exp_an  <= model_an(p);
         exp_seg <= model_seg(p, m_disp);
         exp_dp  <= ~m_disp[16 + (p / DIV) % 4];
         exp_fd  <= ((p % FRAME) == FRAME - 1);
         p       <= p + 1;
         if ((p % FRAME) == FRAME - 1) begin
            if (value_valid) m_disp <= {dp_in, value_in};
            else if (m_pend) m_disp <= m_pend_val;
            m_pend <= 1'b0;
         end else if (value_valid) begin
            m_pend_val <= {dp_in, value_in};
            m_pend     <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if (an_w !== exp_an || seg_w !== exp_seg || dp !== exp_dp || frame_done !== exp_fd) begin
            n_err++;
            $display("FAIL cycle_model t=%0t: an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                     $time, an_w, seg_w, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
         n_cmp++;
         if ($countones(~an_w) > 1) begin
            n_err++;
            $display("FAIL one_hot_anode t=%0t: an=%b, required at most one low", $time, an_w);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic wait_pos(input int pos);
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         if ((p % FRAME) == pos) return;
      end
      n_cmp++;
      n_err++;
      $display("FAIL wait_pos: position %0d not reached, got %0d, required %0d", pos, p % FRAME, pos);
   endtask

   task automatic wait_fd(input string nm);
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) return;
      end
      n_cmp++;
      n_err++;
      $display("FAIL %s: frame_done got 0 for %0d cycles, required a pulse", nm, 4 * FRAME);
   endtask

   task automatic expect_digit(input string nm, input int d, input logic [6:0] s, input logic dpv);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 4 * FRAME && !found; i++) begin
         @(negedge clk);
         if (an_w === ~(4'b0001 << d)) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL %s: anode %0d got never selected, required selected", nm, d);
      end else if (seg_w !== s || dp !== dpv) begin
         n_err++;
         $display("FAIL %s: seg=%b dp=%b, required seg=%b dp=%b", nm, seg_w, dp, s, dpv);
      end
   endtask

   task automatic strobe(input logic [15:0] v, input logic [3:0] d);
      value_in    = v;
      dp_in       = d;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b1;
      value_in    = '0;
      value_valid = 1'b0;
      dp_in       = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_an", {28'd0, an_w}, 32'hF);
      check("rst_seg", {25'd0, seg_w}, 32'h7F);
      check("rst_fd", {31'd0, frame_done}, 32'h0);

      // Test 1: reset scan
      reset = 1'b0;
      @(negedge clk);
      check("t1_an_blank", {28'd0, an_w}, 32'hF);
      check("t1_seg0", {25'd0, seg_w}, 32'h40);
      @(negedge clk);
      check("t1_an0_low", {28'd0, an_w}, 32'hE);
      repeat (3) @(negedge clk);
      check("t1_slot1_blank", {28'd0, an_w}, 32'hF);
      @(negedge clk);
      check("t1_an1_low", {28'd0, an_w}, 32'hD);
      repeat (9) @(negedge clk);
      check("t1_fd_before", {31'd0, frame_done}, 32'h0);
      @(negedge clk);
      check("t1_fd_pulse", {31'd0, frame_done}, 32'h1);
      check("t1_an3_low", {28'd0, an_w}, 32'h7);

      // Test 2: mid-frame load takes effect at the next frame
      wait_pos(5);
      strobe(16'h8F3A, 4'b0001);
`ifdef LEADING_ZERO_BLANK_EN
      expect_digit("t2_old_d3", 3, 7'h7F, 1'b1);
`else
      expect_digit("t2_old_d3", 3, 7'h40, 1'b1);
`endif
      wait_fd("t2_fd");
      expect_digit("t2_d0", 0, 7'b0001000, 1'b0);
      expect_digit("t2_d1", 1, 7'b0110000, 1'b1);
      expect_digit("t2_d2", 2, 7'b0001110, 1'b1);
      expect_digit("t2_d3", 3, 7'b0000000, 1'b1);

      // Test 3: last strobe in a frame wins
      wait_pos(2);
      strobe(16'h1111, 4'b0000);
      @(negedge clk);
      strobe(16'h2222, 4'b0000);
      wait_fd("t3_fd");
      expect_digit("t3_d0", 0, 7'b0100100, 1'b1);
      expect_digit("t3_d3", 3, 7'b0100100, 1'b1);

      // Test 4: strobe on the DIG3 terminal count goes straight to the display
      wait_pos(3);
      strobe(16'h7777, 4'b0000);
      wait_pos(15);
      strobe(16'h5555, 4'b0000);
      expect_digit("t4_d0", 0, 7'b0010010, 1'b1);
      expect_digit("t4_d2", 2, 7'b0010010, 1'b1);
      wait_fd("t4_fd");
      expect_digit("t4_next_d1", 1, 7'b0010010, 1'b1);

      // Test 5: reset during DIG2 discards the pending value
      wait_pos(8);
      strobe(16'hABCD, 4'b0000);
      reset = 1'b1;
      @(negedge clk);
      check("t5_an_off", {28'd0, an_w}, 32'hF);
      check("t5_seg_off", {25'd0, seg_w}, 32'h7F);
      @(negedge clk);
      reset = 1'b0;
      wait_fd("t5_fd1");
      wait_fd("t5_fd2");
      expect_digit("t5_d0", 0, 7'h40, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
      expect_digit("t5_d3", 3, 7'h7F, 1'b1);
`else
      expect_digit("t5_d3", 3, 7'h40, 1'b1);
`endif

`ifdef LEADING_ZERO_BLANK_EN
      // Test 6: leading-zero blanking
      wait_pos(4);
      strobe(16'h0042, 4'b0000);
      wait_fd("t6_fd1");
      expect_digit("t6a_d0", 0, 7'b0100100, 1'b1);
      expect_digit("t6a_d1", 1, 7'b0011001, 1'b1);
      expect_digit("t6a_d2", 2, 7'h7F, 1'b1);
      expect_digit("t6a_d3", 3, 7'h7F, 1'b1);
      wait_pos(4);
      strobe(16'h0000, 4'b0100);
      wait_fd("t6_fd2");
      expect_digit("t6b_d0", 0, 7'h40, 1'b1);
      expect_digit("t6b_d1", 1, 7'h40, 1'b1);
      expect_digit("t6b_d2", 2, 7'h40, 1'b0);
      expect_digit("t6b_d3", 3, 7'h7F, 1'b1);
`endif

      repeat (FRAME) @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage for the sensor controller. It takes a 16-bit count plus per-digit decimal-point requests and time-multiplexes them as four hex digits onto the board's 4-digit common-anode 7-segment display.
Updates are double-buffered and applied only at frame boundaries, so the display never tears. Segment, decimal-point and anode outputs are all active-low and registered.

Parameters:
REFRESH_DIV, 50000, fpga_clk1 cycles per digit slot; legal range is at least 2.
BLANK_CYC, 500, cycles at the start of each slot with all anodes off (ghost suppression); must be less than REFRESH_DIV.

Ports:
fpga_clk1  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
value_in  in  16  value to display; [3:0] drives digit 0 (an0), [15:12] drives digit 3 (an3).
value_valid  in  1  single-cycle strobe; captures value_in and dp_in.
dp_in  in  4  decimal point per digit, 1 = lit.
seg0..seg6  out  1 each  segments a..g, active-low.
dp  out  1  decimal point, active-low.
an0..an3  out  1 each  digit anodes, active-low; at most one is low at any time.
frame_done  out  1  one-cycle pulse at the end of each digit-3 slot.

Behaviour:
Interface: one clock, fpga_clk1. Reset is synchronous and active-high on port reset.

Reset values (held while reset=1):
- refresh counter 0, digit index 0.
- pending and display registers 0, pend flag 0.
- an0..an3 = 1, seg0..seg6 = 1, dp = 1, frame_done = 0.

Refresh counter:
- Counts 0..REFRESH_DIV-1, then wraps.
- At the terminal count the digit index advances 0 -> 1 -> 2 -> 3 -> 0.
- States are DIG0, DIG1, DIG2, DIG3; each lasts exactly REFRESH_DIV cycles. The cycle is free-running after reset.

Anodes:
- While the counter is below BLANK_CYC, all anodes are 1.
- Otherwise the anode of the current digit is 0.
- All outputs are registered, one cycle after the counter and index state. After reset deasserts, an0 first goes low at cycle BLANK_CYC+1.

Segments and decimal point:
- Segments show the hex decode of the display-register nibble for the current digit.
- Encoding is standard hex. 0 drives seg6..seg0 = 1000000, 8 = 0000000, A = 0001000, F = 0001110.
- dp = ~dp_reg[digit].
- During blank cycles, segments and dp still follow the current digit; only the anodes are gated.

Update handshake:
- When value_valid=1, pending <= {dp_in, value_in} and pend <= 1. If several strobes arrive in one frame, the last one wins.
- At the DIG3 terminal count: frame_done = 1 on the next cycle. If pend=1, display <= pending and pend <= 0.
- If value_valid coincides with the DIG3 terminal count, {dp_in, value_in} goes directly into the display register and pend <= 0.
- No backpressure: value_valid is always accepted.

Reset mid-frame: all state returns to reset values on the next edge, and a pending value is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digits 3..1 are blanked (segs all 1, anode still cycles normally) while they and every higher digit are 0. Digit 0 is always shown. A lit decimal point on a digit disables blanking for that digit and all lower digits. Example: 0x0042 shows "42" on an1 and an0.
- Undefined: all four digits are always shown, e.g. "0042".

Decomposition:
- Package seg7_pkg: NUM_DIGITS = 4, the 16-entry segment encoding constants, and the digit-index type (2 bits).
- One sub-module, hex_to_seg7: combinational nibble to 7-bit active-low segment decoder, instantiated once and fed by the digit mux.

Test Plan:
1. Reset scan (REFRESH_DIV=4, BLANK_CYC=1): release reset. Required: an0..an3 = 1 for 1 cycle, then an0=0 for 3 cycles, then an1, an2, an3 in turn; frame_done pulses every 16 cycles; segs = 1000000 throughout.
2. Load 0x8F3A with dp_in=0001 mid-frame. Required: the old value is shown until frame_done; the next frame shows digit0=0001000 with dp=0, digit1=0110000, digit2=0001110, digit3=0000000.
3. Two strobes in one frame, 0x1111 then 0x2222. Required: the next frame shows only 2222.
4. value_valid with 0x5555 exactly on the DIG3 terminal count. Required: the very next frame shows 5555 and pend=0.
5. Assert reset during DIG2 with a pending 0xABCD. Required: all anodes = 1 on the next cycle, and the display shows 0000 after release, not ABCD.
6. With LEADING_ZERO_BLANK_EN defined, load 0x0042, then 0x0000 with dp_in=0100. Required: digits 3 and 2 are blanked for 0x0042; for the second load digit 3 is blanked and digits 2..0 show "0.00".
